// File: rtl/lvds_pkg.sv
// Shared constants and state encoding for the lvds serial link.
package lvds_pkg;

    localparam logic [31:0] LVDS_SYNC_WORD = 32'h5346444B;  // "SFDK"
    localparam int          LVDS_SYNC_W    = 32;

    typedef enum logic {
        HUNT = 1'b0,
        RX   = 1'b1
    } lvds_state_e;

endpackage

// File: rtl/lvds_rx_sync_det.sv
// Input register plus sliding header window; flags a header match combinationally.
module lvds_sync_det
    import lvds_pkg::*;
#(
    parameter logic [LVDS_SYNC_W-1:0] SYNC_WORD = LVDS_SYNC_WORD
) (
    input  logic lvds_clk,
    input  logic rst_n,
    input  logic din_i,
    input  logic en_i,
    input  logic clr_i,
    output logic din_q_o,
    output logic match_o
);

    logic                   din_q;
    logic [LVDS_SYNC_W-2:0] hdr_sr_q;
    logic [LVDS_SYNC_W-1:0] hdr_nxt;

    // Only 31 history bits are kept: the oldest bit would shift out unused.
    assign hdr_nxt = {hdr_sr_q, din_q};
    assign match_o = en_i && (hdr_nxt == SYNC_WORD);
    assign din_q_o = din_q;

    always_ff @(posedge lvds_clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q    <= 1'b0;
            hdr_sr_q <= '0;
        end else begin
            din_q <= din_i;
            if (clr_i)
                hdr_sr_q <= '0;
            else if (en_i)
                hdr_sr_q <= hdr_nxt[LVDS_SYNC_W-2:0];
        end
    end

endmodule

// File: rtl/lvds_rx.sv
// Serial frame receiver: hunts for the header, then deserialises PAYLOAD_WORDS words.
module lvds_rx
    import lvds_pkg::*;
#(
    parameter logic [LVDS_SYNC_W-1:0] SYNC_WORD     = LVDS_SYNC_WORD,
    parameter int                     WORD_W        = 32,
    parameter int                     PAYLOAD_WORDS = 1
) (
    input  logic              lvds_clk,
    input  logic              rst_n,
    input  logic              rx_en,
    input  logic              lvds_data_in,
    output logic              sync_det,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_done,
    output logic              busy,
    output logic [15:0]       frame_cnt
);

    localparam logic [4:0] LAST_BIT  = 5'(WORD_W - 1);
    localparam logic [7:0] LAST_WORD = 8'(PAYLOAD_WORDS - 1);
    localparam bit         HDR_ONLY  = (PAYLOAD_WORDS == 0);

    lvds_state_e       state_q;
    logic [4:0]        bit_cnt_q;
    logic [7:0]        word_cnt_q;
    logic              din_q;
    logic              match;
    logic              word_end;
    logic              last_word;
    logic              hdr_clr;
    logic [WORD_W-1:0] pay_nxt;

    assign word_end  = (state_q == RX) && (bit_cnt_q == LAST_BIT);
    assign last_word = word_end && (word_cnt_q == LAST_WORD);
    // The window restarts empty after every frame so the next header needs fresh bits.
    assign hdr_clr   = !rx_en || last_word || (match && HDR_ONLY);

    lvds_sync_det #(
        .SYNC_WORD(SYNC_WORD)
    ) u_sync (
        .lvds_clk(lvds_clk),
        .rst_n   (rst_n),
        .din_i   (lvds_data_in),
        .en_i    (rx_en && (state_q == HUNT)),
        .clr_i   (hdr_clr),
        .din_q_o (din_q),
        .match_o (match)
    );

    generate
        if (WORD_W > 1) begin : g_pay
            logic [WORD_W-2:0] pay_sr_q;

            assign pay_nxt = {pay_sr_q, din_q};

            always_ff @(posedge lvds_clk or negedge rst_n) begin
                if (!rst_n)
                    pay_sr_q <= '0;
                else if (!rx_en)
                    pay_sr_q <= '0;
                else if (state_q == RX)
                    pay_sr_q <= pay_nxt[WORD_W-2:0];
            end
        end else begin : g_pay1
            assign pay_nxt = din_q;
        end
    endgenerate

    always_ff @(posedge lvds_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            sync_det   <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            sync_det   <= 1'b0;
            data_valid <= 1'b0;
            frame_done <= 1'b0;
            if (!rx_en) begin
                // Abort: partial frame dropped, data_out and frame_cnt kept.
                state_q    <= HUNT;
                bit_cnt_q  <= '0;
                word_cnt_q <= '0;
                busy       <= 1'b0;
            end else begin
                case (state_q)
                    HUNT: begin
                        if (match) begin
                            sync_det  <= 1'b1;
                            frame_cnt <= frame_cnt + 16'd1;
                            if (!HDR_ONLY) begin
                                state_q    <= RX;
                                bit_cnt_q  <= '0;
                                word_cnt_q <= '0;
                                busy       <= 1'b1;
                            end
                        end
                    end
                    RX: begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        if (word_end) begin
                            data_out   <= pay_nxt;
                            data_valid <= 1'b1;
                            bit_cnt_q  <= '0;
                            word_cnt_q <= word_cnt_q + 8'd1;
                            if (last_word) begin
                                frame_done <= 1'b1;
                                state_q    <= HUNT;
                                busy       <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lvds_rx.sv
// Drives one bit stream into four receiver configurations and checks each against a frame-level model.
module tb_lvds_rx;

    localparam logic [31:0] SYNC = 32'h5346444B;

    logic lvds_clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_en = 1'b0;
    logic lvds_data_in = 1'b0;

    always #5 lvds_clk = ~lvds_clk;

    logic [3:0]       sync_w, valid_w, done_w, busy_w;
    logic [3:0][15:0] fcnt_w;
    logic [2:0][31:0] dout_w;
    logic [7:0]       dout3;

    lvds_rx #(.WORD_W(32), .PAYLOAD_WORDS(0)) u0 (
        .lvds_clk(lvds_clk), .rst_n(rst_n), .rx_en(rx_en), .lvds_data_in(lvds_data_in),
        .sync_det(sync_w[0]), .data_out(dout_w[0]), .data_valid(valid_w[0]),
        .frame_done(done_w[0]), .busy(busy_w[0]), .frame_cnt(fcnt_w[0]));
    lvds_rx #(.WORD_W(32), .PAYLOAD_WORDS(1)) u1 (
        .lvds_clk(lvds_clk), .rst_n(rst_n), .rx_en(rx_en), .lvds_data_in(lvds_data_in),
        .sync_det(sync_w[1]), .data_out(dout_w[1]), .data_valid(valid_w[1]),
        .frame_done(done_w[1]), .busy(busy_w[1]), .frame_cnt(fcnt_w[1]));
    lvds_rx #(.WORD_W(32), .PAYLOAD_WORDS(2)) u2 (
        .lvds_clk(lvds_clk), .rst_n(rst_n), .rx_en(rx_en), .lvds_data_in(lvds_data_in),
        .sync_det(sync_w[2]), .data_out(dout_w[2]), .data_valid(valid_w[2]),
        .frame_done(done_w[2]), .busy(busy_w[2]), .frame_cnt(fcnt_w[2]));
    lvds_rx #(.WORD_W(8), .PAYLOAD_WORDS(3)) u3 (
        .lvds_clk(lvds_clk), .rst_n(rst_n), .rx_en(rx_en), .lvds_data_in(lvds_data_in),
        .sync_det(sync_w[3]), .data_out(dout3), .data_valid(valid_w[3]),
        .frame_done(done_w[3]), .busy(busy_w[3]), .frame_cnt(fcnt_w[3]));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got %h exp %h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic int ww(input int id);
        return (id == 3) ? 8 : 32;
    endfunction

    function automatic int nw(input int id);
        return (id == 3) ? 3 : id;
    endfunction

    // Reference model: frame-level view of each receiver.
    logic        m_din;
    logic        m_rx  [4];
    logic [31:0] m_win [4];
    logic [31:0] m_acc [4];
    int          m_nb  [4];
    int          m_wc  [4];
    logic [3:0]  e_s, e_v, e_d;
    logic [15:0] e_fc  [4];
    logic [31:0] e_do  [4];

    task automatic model_rst();
        m_din = 1'b0;
        e_s = '0; e_v = '0; e_d = '0;
        for (int id = 0; id < 4; id++) begin
            m_rx[id] = 1'b0; m_win[id] = '0; m_acc[id] = '0;
            m_nb[id] = 0; m_wc[id] = 0; e_fc[id] = '0; e_do[id] = '0;
        end
    endtask

    task automatic model_edge(input logic rst_now, input logic en_now, input logic din_now);
        if (!rst_now) begin
            model_rst();
            return;
        end
        e_s = '0; e_v = '0; e_d = '0;
        for (int id = 0; id < 4; id++) begin
            if (!en_now) begin
                m_rx[id] = 1'b0; m_win[id] = '0; m_acc[id] = '0; m_nb[id] = 0; m_wc[id] = 0;
            end else if (!m_rx[id]) begin
                m_win[id] = {m_win[id][30:0], m_din};
                if (m_win[id] == SYNC) begin
                    e_s[id] = 1'b1;
                    e_fc[id] = e_fc[id] + 16'd1;
                    if (nw(id) > 0) begin
                        m_rx[id] = 1'b1; m_nb[id] = 0; m_wc[id] = 0;
                    end else begin
                        m_win[id] = '0;
                    end
                end
            end else begin
                m_acc[id] = {m_acc[id][30:0], m_din};
                m_nb[id]++;
                if (m_nb[id] == ww(id)) begin
                    e_do[id] = (ww(id) == 32) ? m_acc[id] : (m_acc[id] & ((32'd1 << ww(id)) - 32'd1));
                    e_v[id] = 1'b1;
                    m_nb[id] = 0;
                    m_wc[id]++;
                    if (m_wc[id] == nw(id)) begin
                        e_d[id] = 1'b1; m_rx[id] = 1'b0; m_win[id] = '0;
                    end
                end
            end
        end
        m_din = din_now;
    endtask

    function automatic logic [63:0] exp_vec(input int id);
        return {12'd0, e_s[id], e_v[id], e_d[id], m_rx[id], e_fc[id], e_do[id]};
    endfunction

    function automatic logic [63:0] obs_vec(input int id);
        logic [31:0] d;
        case (id)
            0: d = dout_w[0];
            1: d = dout_w[1];
            2: d = dout_w[2];
            default: d = {24'd0, dout3};
        endcase
        return {12'd0, sync_w[id], valid_w[id], done_w[id], busy_w[id], fcnt_w[id], d};
    endfunction

    // Event monitor, cleared at the start of each directed phase.
    int          tick_no = 0;
    int          s_cnt [4], v_cnt [4], b_cnt [4], s_last [4], v_last [4], d_last [4];
    logic [31:0] vq1[$];
    logic [31:0] vq2[$];

    task automatic clr_mon();
        for (int id = 0; id < 4; id++) begin
            s_cnt[id] = 0; v_cnt[id] = 0; b_cnt[id] = 0;
            s_last[id] = -1; v_last[id] = -1; d_last[id] = -1;
        end
        vq1.delete();
        vq2.delete();
    endtask

    task automatic tick(input logic b, input logic en);
        lvds_data_in = b;
        rx_en = en;
        @(posedge lvds_clk);
        tick_no++;
        model_edge(rst_n, en, b);
        #1;
        for (int id = 0; id < 4; id++) begin
            chk($sformatf("cyc%0d_u%0d", tick_no, id), obs_vec(id), exp_vec(id));
            if (sync_w[id]) begin s_cnt[id]++; s_last[id] = tick_no; end
            if (valid_w[id]) begin v_cnt[id]++; v_last[id] = tick_no; end
            if (done_w[id]) d_last[id] = tick_no;
            if (busy_w[id]) b_cnt[id]++;
        end
        if (valid_w[1]) vq1.push_back(dout_w[1]);
        if (valid_w[2]) vq2.push_back(dout_w[2]);
    endtask

    task automatic send(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) tick(w[i], 1'b1);
    endtask

    task automatic sep();
        tick(1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b1);
    endtask

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    initial begin
        int          h, l;
        logic [15:0] f0;
        logic [31:0] w;
        logic [31:0] b2b [4];
        b2b[0] = 32'h00000001; b2b[1] = 32'h5346444B; b2b[2] = 32'hCAFEF00D; b2b[3] = 32'h12345678;

        model_rst();
        clr_mon();
        #2;
        for (int id = 0; id < 4; id++) chk($sformatf("reset_u%0d", id), obs_vec(id), 64'd0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        rst_n = 1'b1;

        // Header only.
        clr_mon();
        repeat (40) tick(1'b0, 1'b1);
        send(SYNC, 32);
        h = tick_no;
        repeat (8) tick(1'b0, 1'b1);
        chk("hdr_sync_cnt", s_cnt[0], 1);
        chk("hdr_sync_at", s_last[0], h + 1);
        chk("hdr_fcnt", fcnt_w[0], 1);
        chk("hdr_busy", b_cnt[0], 0);

        // Single frame.
        sep();
        clr_mon();
        send(SYNC, 32);
        send(32'hDEADBEEF, 32);
        l = tick_no;
        repeat (4) tick(1'b0, 1'b1);
        chk("one_vcnt", v_cnt[1], 1);
        chk("one_data", qat(vq1, 0), 32'hDEADBEEF);
        chk("one_valid_at", v_last[1], l + 1);
        chk("one_done_at", d_last[1], l + 1);
        chk("one_busy_len", b_cnt[1], 32);

        // Back-to-back frames with an in-payload header pattern.
        sep();
        clr_mon();
        send(SYNC, 32); send(b2b[0], 32); send(b2b[1], 32);
        send(SYNC, 32); send(b2b[2], 32); send(b2b[3], 32);
        repeat (4) tick(1'b0, 1'b1);
        chk("b2b_vcnt", v_cnt[2], 4);
        for (int i = 0; i < 4; i++) chk($sformatf("b2b_word%0d", i), qat(vq2, i), b2b[i]);
        chk("b2b_sync_cnt", s_cnt[2], 2);

        // Abort mid-payload, then a clean frame.
        sep();
        clr_mon();
        f0 = fcnt_w[1];
        send(SYNC, 32);
        send($urandom, 10);
        tick(1'b0, 1'b0);
        send(SYNC, 32);
        send(32'hA5A5A5A5, 32);
        repeat (40) tick(1'b0, 1'b1);
        chk("abort_vcnt", v_cnt[1], 1);
        chk("abort_data", qat(vq1, 0), 32'hA5A5A5A5);
        chk("abort_fcnt", 16'(fcnt_w[1] - f0), 2);

        // Near-miss header.
        sep();
        clr_mon();
        send(32'h5346444A, 32);
        send(SYNC, 32);
        h = tick_no;
        repeat (4) tick(1'b0, 1'b1);
        chk("near_sync_cnt", s_cnt[0], 1);
        chk("near_sync_at", s_last[0], h + 1);

        // Asynchronous reset mid-payload.
        sep();
        send(SYNC, 32);
        send($urandom, 16);
        rst_n = 1'b0;
        #1;
        model_rst();
        for (int id = 0; id < 4; id++) chk($sformatf("arst_u%0d", id), obs_vec(id), 64'd0);
        tick(1'b0, 1'b1);
        rst_n = 1'b1;
        clr_mon();
        repeat (5) tick(1'b0, 1'b1);
        w = $urandom;
        send(SYNC, 32);
        send(w, 32);
        repeat (40) tick(1'b0, 1'b1);
        chk("arst_vcnt", v_cnt[1], 1);
        chk("arst_data", qat(vq1, 0), w);
        chk("arst_fcnt", fcnt_w[1], 1);

        // Random frames, gaps, noise and aborts; the per-cycle model checks cover these.
        repeat (25) begin
            repeat ($urandom_range(0, 4)) tick(1'b0, 1'b1);
            repeat ($urandom_range(0, 3)) tick(1'($urandom_range(0, 1)), 1'b1);
            send(SYNC, 32);
            repeat ($urandom_range(0, 3)) begin
                if ($urandom_range(0, 7) == 0) tick(1'($urandom_range(0, 1)), 1'b0);
                send($urandom, 32);
            end
        end
        repeat (100) tick(1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lvds_rx.md
Name: lvds_rx

Overview:
- Serial receiver for the lvds_clk single-bit link. Hunts the incoming bitstream, MSB first, for the 32-bit frame header SYNC_WORD ("SFDK").
- After the header it deserialises PAYLOAD_WORDS words of WORD_W bits each and presents them as parallel data with a one-cycle valid strobe.
- Sits at the far end of the link, feeding the frame-processing logic in the lvds_clk domain.

Parameters:
- SYNC_WORD, 32'h5346444B ("SFDK"), header pattern, MSB received first. Must be non-zero.
- WORD_W, 32, payload word width in bits, range 1..32.
- PAYLOAD_WORDS, 1, words captured per frame, range 0..255. 0 means header detection only.

Ports:
- lvds_clk  input  1  bit clock; all logic is on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- rx_en  input  1  receive enable, level-sensitive.
- lvds_data_in  input  1  serial data, synchronous to lvds_clk.
- sync_det  output  1  one-cycle pulse when the header is matched.
- data_out  output  WORD_W  last captured payload word, MSB = first received bit.
- data_valid  output  1  one-cycle pulse; data_out is updated at the same edge.
- frame_done  output  1  one-cycle pulse after the last payload word of a frame.
- busy  output  1  high while in state RX.
- frame_cnt  output  16  count of detected headers, wraps 16'hFFFF -> 0.

Behaviour:
- Reset (async): all registers are cleared.
  - din_q = 0, hdr_sr = 0, pay_sr = 0.
  - bit_cnt = 0, word_cnt = 0, state = HUNT.
  - All outputs are 0; data_out = 0.
- Input stage: lvds_data_in is registered into din_q every cycle. All decoding uses din_q.
- State HUNT (rx_en = 1):
  - Each cycle: hdr_sr <= {hdr_sr[30:0], din_q}.
  - If {hdr_sr[30:0], din_q} == SYNC_WORD: sync_det <= 1 and frame_cnt <= frame_cnt + 1.
  - On that match, if PAYLOAD_WORDS > 0: state <= RX, bit_cnt <= 0, word_cnt <= 0.
  - On that match, if PAYLOAD_WORDS == 0: stay in HUNT and clear hdr_sr to 0.
- Header-detect latency: sync_det is high during the cycle that begins 2 rising edges after the last header bit is presented on lvds_data_in.
- State RX:
  - Each cycle: pay_sr <= {pay_sr[WORD_W-2:0], din_q}, bit_cnt++.
  - The first payload bit is the bit immediately following the header's last bit; no gap.
  - When bit_cnt == WORD_W-1: data_out <= {pay_sr[WORD_W-2:0], din_q}, data_valid <= 1, bit_cnt <= 0, word_cnt++.
  - If that word is the last one (word_cnt == PAYLOAD_WORDS-1):
    - frame_done <= 1 in the same cycle as data_valid.
    - state <= HUNT; hdr_sr <= 0.
    - The next header can be detected after 32 fresh bits, so back-to-back frames with zero gap are received.
  - The header matcher is inactive in RX; a SYNC_WORD pattern inside the payload is treated as data.
- rx_en = 0, in any state, takes effect at the next edge:
  - state <= HUNT; hdr_sr, pay_sr, bit_cnt and word_cnt are cleared.
  - No sync_det, data_valid or frame_done. A partially received frame is discarded silently.
  - data_out and frame_cnt hold their values. din_q keeps sampling.
- Pulses: sync_det, data_valid and frame_done are registered and last exactly 1 cycle.
- busy = (state == RX), registered.
- Reset mid-frame: immediate return to the reset state; no partial word is emitted.
- Idle line: a constant 0 or 1 never matches, because SYNC_WORD is neither all-zero nor all-one.
- Arithmetic widths:
  - bit_cnt: 5 bits.
  - word_cnt: 8 bits.
  - frame_cnt: unsigned 16-bit, modulo wrap.

Decomposition:
- Shared package lvds_pkg holds:
  - LVDS_SYNC_WORD = 32'h5346444B, so the transmit side and this block use one constant.
  - LVDS_SYNC_W = 32.
  - The state encoding HUNT = 1'b0, RX = 1'b1.
- Natural sub-module: lvds_sync_det. It contains the input register, the 32-bit header shift register and the comparator, with inputs clear/enable and a match-pulse output.
- The top level holds the FSM, the payload shift register and the counters.

Test Plan:
- Header only, PAYLOAD_WORDS=0: after reset, drive 40 zeros, then the 32 bits of 32'h5346444B MSB first, then zeros.
  -> sync_det is one pulse, 2 cycles after the last header bit; frame_cnt = 1; busy stays 0.
- One frame, WORD_W=32, PAYLOAD_WORDS=1: send the header, then 32'hDEADBEEF.
  -> data_out = 32'hDEADBEEF with data_valid and frame_done pulsing together, 2 cycles after the last payload bit; busy high for exactly 32 cycles.
- Back-to-back frames, PAYLOAD_WORDS=2: send header+32'h00000001+32'h5346444B, then immediately header+32'hCAFEF00D+32'h12345678.
  -> 4 data_valid pulses with values 1, 5346444B, CAFEF00D, 12345678 in order.
  -> Exactly 2 sync_det pulses; the in-payload "SFDK" does not trigger sync_det.
- Abort: drop rx_en low for 1 cycle after 10 payload bits, then send a full header+32'hA5A5A5A5.
  -> No data_valid for the aborted frame; the next frame yields 32'hA5A5A5A5; frame_cnt = 2.
- Near-miss: stream 32'h5346444A, then 32'h5346444B.
  -> Only the second word produces sync_det.
- Async reset mid-payload: assert rst_n low for 1 cycle at bit 16.
  -> All outputs are 0 immediately; frame_cnt = 0; a subsequent frame is received normally.
